// File: rtl/coeffs_loader.sv
// Coefficient loader: host fills a staging buffer, commit streams every tap into the FIR shadow bank.
// Optional COEFFS_SYMMETRIC_EN: half-size buffer mirrored into even-symmetric linear-phase taps.
module coeffs_loader #(
    parameter int NUM_TAPS   = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_enable,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    input  logic                  commit,
    output logic                  busy,
    output logic                  overrun,
    output logic                  write_enable,
    output logic                  write_done,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] coeffs_out
);

`ifdef COEFFS_SYMMETRIC_EN
    localparam int BUF_DEPTH = NUM_TAPS / 2;
`else
    localparam int BUF_DEPTH = NUM_TAPS;
`endif
    localparam int BUF_AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t state, state_next;

    // One extra bit so the count can reach NUM_TAPS, marking "last tap already presented".
    logic [ADDR_WIDTH:0]   index, index_next;
    logic                  busy_next, overrun_next;
    logic                  write_enable_next, write_done_next;
    logic [ADDR_WIDTH-1:0] write_address_next;
    logic [DATA_WIDTH-1:0] coeffs_next;

    logic [DATA_WIDTH-1:0] stage_mem [BUF_DEPTH];
    logic                  host_addr_ok;
    logic                  stage_wr;
    logic                  dropped;
    logic [BUF_AW-1:0]     rd_sel;

`ifdef COEFFS_SYMMETRIC_EN
    // Only the lower half is storage; the upper half of the tap sequence mirrors it.
    assign host_addr_ok = ~host_wr_addr[ADDR_WIDTH-1];
    assign rd_sel       = index[ADDR_WIDTH-1] ? ~index[BUF_AW-1:0] : index[BUF_AW-1:0];
`else
    assign host_addr_ok = 1'b1;
    assign rd_sel       = index[BUF_AW-1:0];
`endif

    assign stage_wr = !rst && clk_enable && (state == IDLE) && host_wr_en && host_addr_ok;
    assign dropped  = commit || (host_wr_en && host_addr_ok);

    // NOTE: the staging buffer has no reset so it maps onto plain RAM; its contents survive rst.
    always_ff @(posedge clk) begin
        if (stage_wr) begin
            stage_mem[host_wr_addr[BUF_AW-1:0]] <= host_wr_data;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            index         <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            write_enable  <= 1'b0;
            write_done    <= 1'b0;
            write_address <= '0;
            coeffs_out    <= '0;
        end else if (clk_enable) begin
            state         <= state_next;
            index         <= index_next;
            busy          <= busy_next;
            overrun       <= overrun_next;
            write_enable  <= write_enable_next;
            write_done    <= write_done_next;
            write_address <= write_address_next;
            coeffs_out    <= coeffs_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit) state_next = LOAD;
            LOAD:    if (index[ADDR_WIDTH]) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        index_next         = index;
        busy_next          = busy;
        overrun_next       = overrun;
        write_enable_next  = 1'b0;
        write_done_next    = 1'b0;
        write_address_next = '0;
        coeffs_next        = '0;
        case (state)
            IDLE: begin
                index_next = '0;
                if (commit) begin
                    busy_next    = 1'b1;
                    overrun_next = 1'b0;
                end
            end
            LOAD: begin
                if (index[ADDR_WIDTH]) begin
                    write_done_next = 1'b1;
                end else begin
                    write_enable_next  = 1'b1;
                    write_address_next = index[ADDR_WIDTH-1:0];
                    coeffs_next        = stage_mem[rd_sel];
                    index_next         = index + (ADDR_WIDTH + 1)'(1);
                end
                if (dropped) overrun_next = 1'b1;
            end
            DONE: begin
                busy_next  = 1'b0;
                index_next = '0;
                if (dropped) overrun_next = 1'b1;
            end
            default: begin
                busy_next  = 1'b0;
                index_next = '0;
            end
        endcase
    end

endmodule
